// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared types, default timing constants and frame-length helper for tx_arbiter
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam int DEF_BIT_CYCLES = 32;
    localparam int DEF_FRAME_BITS = 10;
    localparam int DEF_GAP_CYCLES = 1;

    // Clocks the arbiter stays busy per frame: the serial frame plus the idle gap.
    function automatic int frame_cycles(input int bit_cycles, input int frame_bits, input int gap);
        return bit_cycles * frame_bits + gap;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational requester pick (round-robin, or fixed priority with TXARB_FIXED_PRIO_EN)
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx,
    output logic             o_valid
);

    logic [IW-1:0] w_cand;

    // Index of the k-th candidate when the search starts at base and wraps at N_REQ-1.
    function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return s[IW-1:0];
    endfunction

    // Walk the candidates in search order; the first active request wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef TXARB_FIXED_PRIO_EN
            w_cand = IW'(k);
`else
            w_cand = slot(i_ptr, k);
`endif
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - shares one serial byte transmitter between N_REQ sources; TXARB_FIXED_PRIO_EN selects fixed priority
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter  int FRAME_BITS = DEF_FRAME_BITS,
    parameter  int GAP_CYCLES = DEF_GAP_CYCLES,
    localparam int IW         = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         DataIn,
    output logic               DataInEn,
    output logic               busy,
    output logic [IW-1:0]      cur_src
);

    localparam int T_FRAME = frame_cycles(BIT_CYCLES, FRAME_BITS, GAP_CYCLES);
    localparam int TW      = $clog2(T_FRAME + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [TW-1:0]     r_timer;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_src;
    logic [N_REQ-1:0]  r_grant;
    logic [7:0]        r_data;

    logic [N_REQ-1:0]  w_pick_grant;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_valid;
    logic [7:0]        w_sel_data;
    logic [IW-1:0]     w_ptr_next;
    logic              w_start;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // A grant is only taken while idle; requests seen during LOAD/WAIT keep waiting.
    assign w_start = (r_state == IDLE) && w_pick_valid;

    // Byte of the winning source.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pick_idx == IW'(k)) begin
                w_sel_data = req_data[8*k +: 8];
            end
        end
    end

    // Pointer after a grant: one past the winner, wrapping; pinned to 0 for fixed priority.
    always_comb begin
        w_ptr_next = '0;
`ifndef TXARB_FIXED_PRIO_EN
        if (w_pick_idx != IW'(N_REQ - 1)) begin
            w_ptr_next = w_pick_idx + IW'(1);
        end
`endif
    end

    // Next-state logic: one LOAD cycle per grant, then WAIT until the frame timer runs out.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                if (r_timer <= TW'(1)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame timer: loaded on grant, counts down through LOAD and WAIT, rests at 0 when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (r_state == IDLE) begin
            r_timer <= w_start ? TW'(T_FRAME) : '0;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - TW'(1);
        end
    end

    // Winner, byte and pointer are captured on the IDLE->LOAD transition and held until the next grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant <= '0;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else if (w_start) begin
            r_grant <= w_pick_grant;
            r_data  <= w_sel_data;
            r_src   <= w_pick_idx;
            r_ptr   <= w_ptr_next;
        end
    end

    assign DataInEn = (r_state == LOAD);
    assign ack      = DataInEn ? r_grant : '0;
    assign busy     = (r_state != IDLE);
    assign DataIn   = r_data;
    assign cur_src  = r_src;

endmodule
